// File: rtl/capture_ram_pkg.sv
// Shared defaults and FSM state encoding for the capture buffer.
package capture_ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 156800;
  localparam int ADDR_W_DEF = 18;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/capture_ram_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read-first read port.
module sdp_ram
  import capture_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Separate read process sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_ram.sv
// Sequential capture buffer: ascending-address word capture with an independent
// registered random-access readback port.
module capture_ram
  import capture_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] count,
  output logic              full,
  output logic              overflow
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              wr_go;

  logic              rd_in_range;
  logic              rd_vld_p1;
  logic              rd_zero_p1;
  logic [DATA_W-1:0] ram_q_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // clear outranks en, so a word arriving with clear is dropped.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_go   = 1'b0;
    if (clear) begin
      state_d = ST_EMPTY;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      case (state_q)
        ST_EMPTY, ST_FILLING: begin
          wr_go   = 1'b1;
          count_d = count_q + ADDR_W'(1);
          state_d = (count_q == LAST_ADDR) ? ST_FULL : ST_FILLING;
        end
        ST_FULL: ovf_d = 1'b1;
        default: begin
          state_d = ST_EMPTY;
          count_d = '0;
        end
      endcase
    end
  end

  assign rd_in_range = (rd_addr < DEPTH_A);

  sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(MEM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_go & ~rst),
    .waddr(count_q[MEM_AW-1:0]),
    .wdata(data_in),
    .re   (rd_en & rd_in_range & ~rst),
    .raddr(rd_addr[MEM_AW-1:0]),
    .rdata(ram_q_p1)
  );

  // ---- read stage p1: valid and out-of-range/reset zero flag ride with ram_q_p1
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p1  <= 1'b0;
      rd_zero_p1 <= 1'b1;
    end else begin
      rd_vld_p1 <= rd_en;
      if (rd_en) rd_zero_p1 <= ~rd_in_range;
    end
  end

  assign rd_data  = rd_zero_p1 ? '0 : ram_q_p1;
  assign rd_valid = rd_vld_p1;
  assign count    = count_q;
  assign full     = (state_q == ST_FULL);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_capture_ram.sv
// Bench for capture_ram: directed scenarios then random traffic against an array model.
module tb_capture_ram;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] count;
  logic              full;
  logic              overflow;

  capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array plus word count, sticky overflow and last read.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];
  int                m_count = 0;
  bit                m_ovf = 0;
  bit                m_rdv = 0;
  logic [DATA_W-1:0] m_rdd = '0;
  bit                m_rdd_known = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [DATA_W-1:0] d,
                      input bit c, input bit re, input logic [ADDR_W-1:0] ra);
    rst = r; en = e; data_in = d; clear = c; rd_en = re; rd_addr = ra;
    @(posedge clk);
    if (r) begin
      m_count = 0; m_ovf = 0; m_rdv = 0; m_rdd = '0; m_rdd_known = 1;
    end else begin
      m_rdv = re;
      if (re) begin
        if (int'(ra) >= DEPTH) begin
          m_rdd = '0; m_rdd_known = 1;
        end else begin
          m_rdd = m_mem[ra]; m_rdd_known = m_known[ra];
        end
      end
      if (c) begin
        m_count = 0; m_ovf = 0;
      end else if (e) begin
        if (m_count < DEPTH) begin
          m_mem[m_count] = d; m_known[m_count] = 1; m_count++;
        end else m_ovf = 1;
      end
    end
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_rdd_known) chk("rd_data", 32'(rd_data), 32'(m_rdd));
    rst = 0; en = 0; clear = 0; rd_en = 0;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    step(0, 1, d, 0, 0, '0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    step(0, 0, '0, 0, 1, a);
  endtask

  initial begin
    logic [DATA_W-1:0] words [4];
    words[0] = 16'h0000; words[1] = 16'h1111; words[2] = 16'h1010; words[3] = 16'h0101;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    // Reset then write four words and read them back.
    step(1, 0, '0, 0, 0, '0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    for (int i = 0; i < 4; i++) wr(words[i]);
    chk("four_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      rd(ADDR_W'(i));
      chk($sformatf("readback%0d", i), 32'(rd_data), 32'(words[i]));
      chk("readback_valid", 32'(rd_valid), 32'd1);
    end

    // Full and overflow with five words A..E.
    step(0, 0, '0, 1, 0, '0);
    wr(16'hAAAA); wr(16'hBBBB); wr(16'hCCCC);
    chk("not_full_3", 32'(full), 32'd0);
    wr(16'hDDDD);
    chk("full_4", 32'(full), 32'd1);
    chk("no_ovf_4", 32'(overflow), 32'd0);
    wr(16'hEEEE);
    chk("ovf_5", 32'(overflow), 32'd1);
    chk("count_stuck", 32'(count), 32'd4);
    rd(3'd3);
    chk("addr3_D", 32'(rd_data), 32'h0000DDDD);

    // clear and en together at count 2.
    step(0, 0, '0, 1, 0, '0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    wr(16'hF0F0); wr(16'hF1F1);
    step(0, 1, 16'hBEEF, 1, 0, '0);
    chk("clr_en_count", 32'(count), 32'd0);
    chk("clr_en_ovf", 32'(overflow), 32'd0);
    rd(3'd0);
    chk("clr_keeps_addr0", 32'(rd_data), 32'h0000F0F0);
    wr(16'h1234);
    rd(3'd0);
    chk("after_clr_addr0", 32'(rd_data), 32'h00001234);

    // Read-first collision at address 2 (still holds C).
    wr(16'h2222);
    step(0, 1, 16'h5A5A, 0, 1, 3'd2);
    chk("read_first_old", 32'(rd_data), 32'h0000CCCC);
    rd(3'd2);
    chk("read_first_new", 32'(rd_data), 32'h00005A5A);

    // Mid-capture reset.
    step(0, 0, '0, 1, 0, '0);
    wr(16'h3333); wr(16'h4444); wr(16'h5555);
    step(1, 0, '0, 0, 1, 3'd1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    wr(16'h7777);
    rd(3'd0);
    chk("post_rst_addr0", 32'(rd_data), 32'h00007777);

    // Out-of-range read, then rd_valid drops while rd_data holds.
    rd(3'd4);
    chk("oor_data", 32'(rd_data), 32'd0);
    chk("oor_valid", 32'(rd_valid), 32'd1);
    rd(3'd0);
    step(0, 0, '0, 0, 0, '0);
    chk("hold_valid", 32'(rd_valid), 32'd0);
    chk("hold_data", 32'(rd_data), 32'h00007777);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(63) == 0), $urandom_range(1), DATA_W'($urandom),
           ($urandom_range(15) == 0), $urandom_range(1), ADDR_W'($urandom_range(7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
